// File: rtl/q_zigzag.sv
// q_zigzag: double-buffered 8x8 zigzag reorder stage.
// Accepts raster-order coefficient pairs and streams each block one coefficient
// per cycle in JPEG zigzag order. Two banks let one block fill while the
// previous one drains.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for the bank at rd_bank to become full
// S_STREAM | walking rd_cnt 0..63 through the zigzag table of rd_bank
module q_zigzag #(
    parameter int COEF_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2*COEF_W-1:0]   in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [COEF_W-1:0]     out_data_o,
    output logic [5:0]            out_idx_o,
    output logic                  out_last_o
);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    // zigzag position -> raster address
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [COEF_W-1:0] mem_q [2][64];
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, rd_bank_q;
    logic [4:0]        wr_cnt_q;
    // Extra MSB marks "all 64 loaded" so the block is not re-read while
    // the final coefficient waits for its handshake.
    logic [6:0]        rd_cnt_q;
    state_t            state_q;

    logic wr_fire, wr_done, rd_done, rd_load;

    assign in_ready_o = !full_q[wr_bank_q];
    assign wr_fire    = in_valid_i && in_ready_o;
    assign wr_done    = wr_fire && (wr_cnt_q == 5'd31);
    assign rd_done    = out_valid_o && out_ready_i && out_last_o;
    assign rd_load    = (state_q == S_STREAM) && (!out_valid_o || out_ready_i) && !rd_cnt_q[6];

    // Coefficient storage; contents survive reset since full flags gate use.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][{wr_cnt_q, 1'b0}] <= in_data_i[2*COEF_W-1:COEF_W];
            mem_q[wr_bank_q][{wr_cnt_q, 1'b1}] <= in_data_i[COEF_W-1:0];
        end
    end

    // Full flags: set by the writer, cleared by the reader; never the same bank at once.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    // Write pointer and bank flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= 5'd0;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 5'd1;
                if (wr_done) wr_bank_q <= !wr_bank_q;
            end
        end
    end

    // Read FSM with registered output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= 7'd0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= 6'd0;
            out_last_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q  <= S_STREAM;
                        rd_cnt_q <= 7'd0;
                    end
                end
                S_STREAM: begin
                    if (rd_load) begin
                        out_data_o  <= mem_q[rd_bank_q][ZZ[rd_cnt_q[5:0]]];
                        out_idx_o   <= rd_cnt_q[5:0];
                        out_last_o  <= (rd_cnt_q[5:0] == 6'd63);
                        out_valid_o <= 1'b1;
                        rd_cnt_q    <= rd_cnt_q + 7'd1;
                    end else if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                    end
                    if (rd_done) begin
                        state_q   <= S_IDLE;
                        rd_bank_q <= !rd_bank_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_zigzag.sv
// tb_q_zigzag: directed + randomized bench for q_zigzag against a zigzag
// reference built by walking anti-diagonals of the 8x8 block.
module tb_q_zigzag;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;

    q_zigzag #(.COEF_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_idx_o(out_idx), .out_last_o(out_last)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          zz_ref [64];
    logic [31:0] src_q [$];
    logic [31:0] cur_words [32];
    int          cur_n;
    logic [15:0] exp_d [$];
    int          exp_i [$];
    logic [15:0] got [64];
    int          rdy_mode;
    bit          vld_rand;
    int          cyc, n_acc, last_acc_cyc, first_valid_cyc, run, max_run;
    bit          last_hs, pre_in_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // zigzag = anti-diagonals, alternating direction
    task automatic build_zz();
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_ref[p] = r * 8 + (s - r); p++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_ref[p] = r * 8 + (s - r); p++; end
            end
        end
    endtask

    task automatic model_accept(input logic [31:0] w);
        logic [15:0] rast [64];
        cur_words[cur_n] = w;
        cur_n++;
        if (cur_n == 32) begin
            for (int k = 0; k < 32; k++) begin
                rast[2*k]   = cur_words[k][31:16];
                rast[2*k+1] = cur_words[k][15:0];
            end
            for (int p = 0; p < 64; p++) begin
                exp_d.push_back(rast[zz_ref[p]]);
                exp_i.push_back(p);
            end
            cur_n = 0;
            last_acc_cyc = cyc;
        end
    endtask

    task automatic check_out(input logic [15:0] d, input logic [5:0] ix, input logic l);
        if (exp_d.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
        end else begin
            logic [15:0] ed;
            int          ei;
            ed = exp_d.pop_front();
            ei = exp_i.pop_front();
            chk("out_data", {16'd0, d}, {16'd0, ed});
            chk("out_idx", {26'd0, ix}, ei);
            chk("out_last", {31'd0, l}, (ei == 63) ? 32'd1 : 32'd0);
            got[ix] = d;
        end
    endtask

    // One clock: drive at negedge, sample pre-edge, update model at posedge.
    task automatic cycle();
        bit          acc, hs, l;
        logic [15:0] d;
        logic [5:0]  ix;
        in_valid = (src_q.size() != 0) && (!vld_rand || $urandom_range(0, 3) != 0);
        in_data  = (src_q.size() != 0) ? src_q[0] : 32'd0;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        d = out_data; ix = out_idx; l = out_last;
        pre_in_ready = in_ready;
        @(posedge clk);
        cyc++;
        if (acc) begin
            n_acc++;
            model_accept(src_q.pop_front());
        end
        if (hs) check_out(d, ix, l);
        last_hs = hs && l;
        @(negedge clk);
        if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            run = 0;
        end
    endtask

    task automatic drain(input int bound, input string tag);
        int k = 0;
        while (!(src_q.size() == 0 && exp_d.size() == 0 && cur_n == 0 && !out_valid) && k < bound) begin
            cycle();
            k++;
        end
        chk(tag, {31'd0, k < bound}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        src_q.delete(); exp_d.delete(); exp_i.delete();
        cur_n = 0;
    endtask

    task automatic phase_start();
        n_acc = 0; first_valid_cyc = -1; run = 0; max_run = 0;
        for (int i = 0; i < 64; i++) got[i] = 16'hDEAD;
    endtask

    initial begin
        bit found;
        build_zz();
        cyc = 0; rdy_mode = 1; vld_rand = 0;
        do_reset();

        // reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_idx", {26'd0, out_idx}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single ramp block, continuous output
        phase_start();
        for (int k = 0; k < 32; k++) src_q.push_back({16'(2*k), 16'(2*k+1)});
        drain(400, "ramp_drain");
        chk("ramp_latency", first_valid_cyc - last_acc_cyc, 32'd2);
        chk("ramp_run64", max_run, 32'd64);
        chk("ramp_z0", {16'd0, got[0]}, 32'd0);
        chk("ramp_z2", {16'd0, got[2]}, 32'd8);
        chk("ramp_z3", {16'd0, got[3]}, 32'd16);
        chk("ramp_z35", {16'd0, got[35]}, 32'd56);
        chk("ramp_z63", {16'd0, got[63]}, 32'd63);

        // signed passthrough
        phase_start();
        src_q.push_back(32'h8001FFFF);
        for (int k = 1; k < 32; k++) src_q.push_back(32'd0);
        drain(400, "signed_drain");
        chk("signed_z0", {16'd0, got[0]}, 32'h8001);
        chk("signed_z1", {16'd0, got[1]}, 32'hFFFF);
        chk("signed_z2", {16'd0, got[2]}, 32'h0);

        // back-pressure: three blocks offered, output stalled
        phase_start();
        rdy_mode = 0;
        for (int k = 0; k < 96; k++) src_q.push_back($urandom);
        for (int c = 0; c < 40; c++) cycle();
        chk("bp_hold_idx_a", {26'd0, out_idx}, 32'd0);
        chk("bp_hold_data_a", {16'd0, out_data}, {16'd0, exp_d[0]});
        for (int c = 0; c < 40; c++) cycle();
        chk("bp_accepts", n_acc, 32'd64);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_idx_b", {26'd0, out_idx}, 32'd0);
        chk("bp_hold_data_b", {16'd0, out_data}, {16'd0, exp_d[0]});
        rdy_mode = 1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            cycle();
            if (last_hs) found = 1;
        end
        chk("bp_release_seen", {31'd0, found}, 32'd1);
        chk("bp_ready_at_last", {31'd0, pre_in_ready}, 32'd0);
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        drain(1000, "bp_drain");

        // random data, random valid/ready, ten blocks back to back
        phase_start();
        rdy_mode = 2; vld_rand = 1;
        for (int k = 0; k < 320; k++) src_q.push_back($urandom);
        drain(6000, "rand_drain");
        chk("rand_accepts", n_acc, 32'd320);

        // reset in the middle of streaming with a half-written second block
        phase_start();
        rdy_mode = 1; vld_rand = 0;
        for (int k = 0; k < 48; k++) src_q.push_back($urandom);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            cycle();
            if (out_valid && out_idx == 6'd20) found = 1;
        end
        chk("mid_idx20_seen", {31'd0, found}, 32'd1);
        do_reset();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        phase_start();
        for (int k = 0; k < 32; k++) src_q.push_back($urandom);
        drain(400, "mid_fresh_drain");
        chk("mid_fresh_run64", max_run, 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
